axi_mem_wr_slv: RTL

//  AXI4 write-channel responder (AW/W/B) that turns write bursts into per-beat writes on a word-wide

---
 rtl/axi_mem_wr_slv_pkg.sv | 77 +++++++
 rtl/axi_burst_addr_gen.sv | 42 ++++
 rtl/axi_mem_wr_slv.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_wr_slv_pkg.sv
// Shared definitions for the AXI4 write responder and its burst address generator.
// Provides the AXI_* width macros (overridable on the command line), typed width
// constants, response and burst codes, and the write FSM state encoding.
// Optional feature macro used by the importing files: AXI_SLV_WRAP_BURST_EN.

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

package axi_mem_wr_slv_pkg;

  localparam int unsigned AxiIdW     = `AXI_ID_WIDTH;
  localparam int unsigned AxiAddrW   = `AXI_ADDR_WIDTH;
  localparam int unsigned AxiLenW    = `AXI_LEN_WIDTH;
  localparam int unsigned AxiSizeW   = `AXI_SIZE_WIDTH;
  localparam int unsigned AxiBurstW  = `AXI_BURST_WIDTH;
  localparam int unsigned AxiLockW   = `AXI_LOCK_WIDTH;
  localparam int unsigned AxiCacheW  = `AXI_CACHE_WIDTH;
  localparam int unsigned AxiProtW   = `AXI_PROT_WIDTH;
  localparam int unsigned AxiQosW    = `AXI_QOS_WIDTH;
  localparam int unsigned AxiRegionW = `AXI_REGION_WIDTH;
  localparam int unsigned AxiDataW   = `AXI_DATA_WIDTH;
  localparam int unsigned AxiStrbW   = `AXI_DATA_WIDTH / 8;
  localparam int unsigned AxiRespW   = `AXI_RESP_WIDTH;

  localparam logic [AxiRespW-1:0] RespOkay   = AxiRespW'(0);
  localparam logic [AxiRespW-1:0] RespSlverr = AxiRespW'(2);
  localparam logic [AxiRespW-1:0] RespDecerr = AxiRespW'(3);

  localparam logic [AxiBurstW-1:0] BurstFixed = AxiBurstW'(0);
  localparam logic [AxiBurstW-1:0] BurstIncr  = AxiBurstW'(1);
  localparam logic [AxiBurstW-1:0] BurstWrap  = AxiBurstW'(2);
  localparam logic [AxiBurstW-1:0] BurstRsvd  = AxiBurstW'(3);

  // Largest legal awsize: a full data-bus beat.
  localparam logic [AxiSizeW-1:0] MaxSize = AxiSizeW'($clog2(AxiStrbW));

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StResp
  } wr_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for an AXI burst (FIXED / INCR / WRAP).
// Ports: addr_i current beat address, size_i log2 bytes per beat, len_i beats-1,
//        burst_i burst type, next_addr_o address of the following beat.
// WRAP support only when AXI_SLV_WRAP_BURST_EN is defined; otherwise WRAP holds the address.

module axi_burst_addr_gen
  import axi_mem_wr_slv_pkg::*;
(
  input  logic [AxiAddrW-1:0]  addr_i,
  input  logic [AxiSizeW-1:0]  size_i,
  input  logic [AxiLenW-1:0]   len_i,
  input  logic [AxiBurstW-1:0] burst_i,
  output logic [AxiAddrW-1:0]  next_addr_o
);

  logic [AxiAddrW-1:0] beat_bytes;
  logic [AxiAddrW-1:0] incr_addr;
`ifdef AXI_SLV_WRAP_BURST_EN
  logic [AxiAddrW-1:0] wrap_mask;
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  always_comb begin
    beat_bytes  = AxiAddrW'(1) << size_i;
    // Align down first so an unaligned INCR start lands on the next aligned beat.
    incr_addr   = (addr_i & ~(beat_bytes - AxiAddrW'(1))) + beat_bytes;
`ifdef AXI_SLV_WRAP_BURST_EN
    wrap_mask   = ((AxiAddrW'(len_i) + AxiAddrW'(1)) << size_i) - AxiAddrW'(1);
`endif
    next_addr_o = addr_i;
    case (burst_i)
      BurstIncr: next_addr_o = incr_addr;
`ifdef AXI_SLV_WRAP_BURST_EN
      BurstWrap: next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
      default:   next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_mem_wr_slv.sv
// AXI4 write-channel responder (AW/W/B) driving a word-wide SRAM write port.
// One outstanding burst; each accepted W beat becomes a one-cycle mem_we pulse.
// Ports: clk, rst (async, active high); AXI AW/W/B slave channels (axi_slv_*);
//        mem_we/mem_addr/mem_wdata/mem_wstrb SRAM write port (word index within window).
// All outputs are registered. Errors: DECERR for out-of-window beats, SLVERR for bad size,
// bad burst type / wrap length, early or missing wlast. DECERR outranks SLVERR.
// Build option: AXI_SLV_WRAP_BURST_EN enables WRAP bursts (otherwise WRAP -> SLVERR).

module axi_mem_wr_slv
  import axi_mem_wr_slv_pkg::*;
#(
  parameter logic [AxiAddrW-1:0] MEM_BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned         MEM_DEPTH_WORDS = 4096
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [AxiIdW-1:0]                  axi_slv_awid,
  input  logic [AxiAddrW-1:0]                axi_slv_awaddr,
  input  logic [AxiLenW-1:0]                 axi_slv_awlen,
  input  logic [AxiSizeW-1:0]                axi_slv_awsize,
  input  logic [AxiBurstW-1:0]               axi_slv_awburst,
  input  logic [AxiLockW-1:0]                axi_slv_awlock,
  input  logic [AxiCacheW-1:0]               axi_slv_awcache,
  input  logic [AxiProtW-1:0]                axi_slv_awprot,
  input  logic [AxiQosW-1:0]                 axi_slv_awqos,
  input  logic [AxiRegionW-1:0]              axi_slv_awregion,
  input  logic                               axi_slv_awvalid,
  output logic                               axi_slv_awready,
  input  logic [AxiDataW-1:0]                axi_slv_wdata,
  input  logic [AxiStrbW-1:0]                axi_slv_wstrb,
  input  logic                               axi_slv_wlast,
  input  logic                               axi_slv_wvalid,
  output logic                               axi_slv_wready,
  output logic [AxiIdW-1:0]                  axi_slv_bid,
  output logic [AxiRespW-1:0]                axi_slv_bresp,
  output logic                               axi_slv_bvalid,
  input  logic                               axi_slv_bready,
  output logic                               mem_we,
  output logic [$clog2(MEM_DEPTH_WORDS)-1:0] mem_addr,
  output logic [AxiDataW-1:0]                mem_wdata,
  output logic [AxiStrbW-1:0]                mem_wstrb
);

  localparam int unsigned MemAw    = $clog2(MEM_DEPTH_WORDS);
  localparam int unsigned ByteOffW = $clog2(AxiStrbW);
  localparam int unsigned CntW     = AxiLenW + 1;
  localparam logic [AxiAddrW-1:0] WinBytes = AxiAddrW'(MEM_DEPTH_WORDS * AxiStrbW);

  wr_state_e            state_q, state_d;
  logic                 awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [AxiIdW-1:0]    bid_q, bid_d, id_q, id_d;
  logic [AxiRespW-1:0]  bresp_q, bresp_d, resp_q, resp_d, aw_resp;
  logic                 mem_we_q, mem_we_d;
  logic [MemAw-1:0]     mem_addr_q, mem_addr_d;
  logic [AxiDataW-1:0]  mem_wdata_q, mem_wdata_d;
  logic [AxiStrbW-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic [AxiAddrW-1:0]  addr_q, addr_d, next_addr, aw_off, beat_off;
  logic [AxiLenW-1:0]   len_q, len_d;
  logic [AxiSizeW-1:0]  size_q, size_d;
  logic [AxiBurstW-1:0] burst_q, burst_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 in_burst;

  logic unused_ok;
  assign unused_ok = ^{axi_slv_awlock, axi_slv_awcache, axi_slv_awprot, axi_slv_awqos,
                       axi_slv_awregion, beat_off};

  axi_burst_addr_gen u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  // Error classification of an incoming AW, evaluated in the handshake cycle.
  always_comb begin
    aw_off  = axi_slv_awaddr - MEM_BASE_ADDR;
    aw_resp = RespOkay;
    if (axi_slv_awsize > MaxSize || axi_slv_awburst == BurstRsvd) aw_resp = RespSlverr;
`ifdef AXI_SLV_WRAP_BURST_EN
    if (axi_slv_awburst == BurstWrap &&
        !(axi_slv_awlen inside {AxiLenW'(1), AxiLenW'(3), AxiLenW'(7), AxiLenW'(15)})) begin
      aw_resp = RespSlverr;
    end
`else
    if (axi_slv_awburst == BurstWrap) aw_resp = RespSlverr;
`endif
    // Unsigned wrap of the subtraction makes addresses below the base fall out too.
    if (aw_off >= WinBytes) aw_resp = RespDecerr;
  end

  always_comb begin
    state_d     = state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    beat_off    = addr_q - MEM_BASE_ADDR;
    in_burst    = cnt_q <= {1'b0, len_q};

    unique case (state_q)
      StIdle: begin
        awready_d = 1'b1;
        if (axi_slv_awvalid && awready_q) begin
          state_d   = StData;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          id_d      = axi_slv_awid;
          addr_d    = axi_slv_awaddr;
          len_d     = axi_slv_awlen;
          size_d    = axi_slv_awsize;
          burst_d   = axi_slv_awburst;
          cnt_d     = '0;
          resp_d    = aw_resp;
        end
      end
      StData: begin
        if (axi_slv_wvalid && wready_q) begin
          if (in_burst && beat_off >= WinBytes) resp_d = RespDecerr;
          // Beats past awlen (missing wlast) are drained but never written.
          if (resp_d == RespOkay && in_burst) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = beat_off[ByteOffW +: MemAw];
            mem_wdata_d = axi_slv_wdata;
            mem_wstrb_d = axi_slv_wstrb;
          end
          if (resp_d == RespOkay &&
              ((axi_slv_wlast && cnt_q < {1'b0, len_q}) ||
               (!axi_slv_wlast && cnt_q == {1'b0, len_q}))) begin
            resp_d = RespSlverr;
          end
          addr_d = next_addr;
          cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
          if (axi_slv_wlast) begin
            state_d  = StResp;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = resp_d;
          end
        end
      end
      StResp: begin
        if (axi_slv_bready) begin
          state_d   = StIdle;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RespOkay;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= BurstFixed;
      cnt_q       <= '0;
      resp_q      <= RespOkay;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
    end
  end

  assign axi_slv_awready = awready_q;
  assign axi_slv_wready  = wready_q;
  assign axi_slv_bvalid  = bvalid_q;
  assign axi_slv_bid     = bid_q;
  assign axi_slv_bresp   = bresp_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_wstrb       = mem_wstrb_q;

endmodule
